// File: rtl/regfile_sb_if.sv
// Register-file/scoreboard bus: read ports, writeback port, issue port, flush and busy count.
// No handshake: every input is sampled at each rising edge, every output is combinational or registered state.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            flush;
    logic [AW:0]     busy_cnt;

    modport master (
        output a1, a2, we3, a3, wd3, issue_valid, issue_rd, flush,
        input  rd1, rd2, busy1, busy2, busy_cnt
    );

    modport slave (
        input  a1, a2, we3, a3, wd3, issue_valid, issue_rd, flush,
        output rd1, rd2, busy1, busy2, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard, flush and registered busy count.
// Define REGFILE_BYPASS_EN to forward a same-cycle writeback straight to the read ports.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic        clk,
    input  logic        reset_n,
    regfile_sb_if.slave rf
);
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic [AW:0]      busy_cnt_q;
    logic             wr_en;

    assign wr_en = rf.we3 && (rf.a3 != '0);

    // Set is applied after clear so a new producer supersedes a retiring one.
    always_comb begin
        busy_nxt = busy;
        if (rf.flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en)
                busy_nxt[rf.a3] = 1'b0;
            if (rf.issue_valid && (rf.issue_rd != '0))
                busy_nxt[rf.issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_en)
                regs[rf.a3] <= rf.wd3;
            busy       <= busy_nxt;
            busy_cnt_q <= cnt_nxt;
        end
    end

    assign rf.busy_cnt = busy_cnt_q;

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = wr_en && (rf.a1 == rf.a3);
    assign hit2 = wr_en && (rf.a2 == rf.a3);

    // A forwarded read is idle unless an unflushed issue re-claims the same register.
    always_comb begin
        rf.rd1   = (rf.a1 == '0) ? '0 : regs[rf.a1];
        rf.rd2   = (rf.a2 == '0) ? '0 : regs[rf.a2];
        rf.busy1 = busy[rf.a1];
        rf.busy2 = busy[rf.a2];
        if (hit1) begin
            rf.rd1   = rf.wd3;
            rf.busy1 = rf.issue_valid && (rf.issue_rd == rf.a1) && !rf.flush;
        end
        if (hit2) begin
            rf.rd2   = rf.wd3;
            rf.busy2 = rf.issue_valid && (rf.issue_rd == rf.a2) && !rf.flush;
        end
    end
`else
    always_comb begin
        rf.rd1   = (rf.a1 == '0) ? '0 : regs[rf.a1];
        rf.rd2   = (rf.a2 == '0) ? '0 : regs[rf.a2];
        rf.busy1 = busy[rf.a1];
        rf.busy2 = busy[rf.a2];
    end
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: cycle-level behavioural model plus directed literal checks.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic clk;
    logic reset_n;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rf      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];

    function automatic int m_count();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            foreach (m_reg[i]) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            chk_en = 1'b1;
        end else begin
            if (bus.we3 && bus.a3 != 0) begin
                m_reg[bus.a3]  = bus.wd3;
                m_busy[bus.a3] = 1'b0;
            end
            if (bus.issue_valid && bus.issue_rd != 0)
                m_busy[bus.issue_rd] = 1'b1;
            if (bus.flush)
                foreach (m_busy[i]) m_busy[i] = 1'b0;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (bus.we3 && bus.a3 != 0 && a == bus.a3) return bus.wd3;
`endif
        return (a == 0) ? '0 : m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (bus.we3 && bus.a3 != 0 && a == bus.a3)
            return bus.issue_valid && bus.issue_rd == a && !bus.flush;
`endif
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd1",      bus.rd1,   exp_rd(bus.a1));
            chk("rd2",      bus.rd2,   exp_rd(bus.a2));
            chk("busy1",    32'(bus.busy1), 32'(exp_busy(bus.a1)));
            chk("busy2",    32'(bus.busy2), 32'(exp_busy(bus.a2)));
            chk("busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.we3         = 1'b0;
        bus.a3          = '0;
        bus.wd3         = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.we3 = 1'b1;
        bus.a3  = a;
        bus.wd3 = d;
    endtask

    task automatic iss(input logic [AW-1:0] a);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = a;
    endtask

    task automatic read1(input logic [AW-1:0] a);
        bus.a1 = a;
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n = 1'b0;
        bus.a1  = '0;
        bus.a2  = '0;
        idle();
        step();
        step();
        reset_n = 1'b1;
        chk("reset rd1", bus.rd1, 32'h0);
        chk("reset busy_cnt", 32'(bus.busy_cnt), 32'd0);

        // Reset flow: write x5, then a one-cycle reset clears it.
        wr(5, 32'hDEADBEEF);
        step();
        idle();
        read1(5);
        chk("x5 written", bus.rd1, 32'hDEADBEEF);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        #1;
        chk("x5 after reset", bus.rd1, 32'h0);
        chk("cnt after reset", 32'(bus.busy_cnt), 32'd0);

        // Register 0 is never written and never busy.
        wr(0, 32'hFFFFFFFF);
        iss(0);
        read1(0);
        step();
        idle();
        #1;
        chk("x0 rd1", bus.rd1, 32'h0);
        chk("x0 busy1", 32'(bus.busy1), 32'd0);
        chk("x0 busy_cnt", 32'(bus.busy_cnt), 32'd0);

        // Scoreboard round trip on x7.
        iss(7);
        read1(7);
        step();
        idle();
        #1;
        chk("x7 busy after issue", 32'(bus.busy1), 32'd1);
        chk("cnt after issue x7", 32'(bus.busy_cnt), 32'd1);
        step();
        wr(7, 32'h12345678);
        step();
        idle();
        #1;
        chk("x7 busy after wb", 32'(bus.busy1), 32'd0);
        chk("x7 data", bus.rd1, 32'h12345678);
        chk("cnt after wb x7", 32'(bus.busy_cnt), 32'd0);

        // Same-edge issue and writeback on x9: set wins, data still written.
        iss(9);
        step();
        idle();
        iss(9);
        wr(9, 32'hA5A5A5A5);
        read1(9);
        step();
        idle();
        #1;
        chk("x9 collision busy", 32'(bus.busy1), 32'd1);
        chk("x9 collision data", bus.rd1, 32'hA5A5A5A5);
        chk("x9 collision cnt", 32'(bus.busy_cnt), 32'd1);
        wr(9, 32'h0000_0009);
        step();
        idle();

        // Flush overrides a simultaneous issue.
        for (int r = 1; r <= 3; r++) begin
            iss(AW'(r));
            step();
        end
        idle();
        #1;
        chk("cnt before flush", 32'(bus.busy_cnt), 32'd3);
        bus.flush = 1'b1;
        iss(4);
        step();
        idle();
        #1;
        chk("cnt after flush", 32'(bus.busy_cnt), 32'd0);
        for (int r = 1; r <= 4; r++) begin
            read1(AW'(r));
            chk("busy after flush", 32'(bus.busy1), 32'd0);
        end

        // Write-to-read bypass on x10.
        wr(10, 32'h11110000);
        step();
        idle();
        wr(10, 32'hCAFEF00D);
        bus.a2 = 10;
        read1(10);
`ifdef REGFILE_BYPASS_EN
        chk("x10 bypass pre-edge", bus.rd1, 32'hCAFEF00D);
`else
        chk("x10 no bypass pre-edge", bus.rd1, 32'h11110000);
`endif
        step();
        idle();
        #1;
        chk("x10 post-edge", bus.rd1, 32'hCAFEF00D);

        // Reset mid-operation drops pending producers; a later write leaves busy clear.
        iss(3);
        step();
        iss(4);
        step();
        idle();
        reset_n = 1'b0;
        iss(5);
        step();
        reset_n = 1'b1;
        idle();
        #1;
        chk("cnt after mid reset", 32'(bus.busy_cnt), 32'd0);
        wr(3, 32'h0BAD_F00D);
        read1(3);
        step();
        idle();
        #1;
        chk("x3 orphan write data", bus.rd1, 32'h0BAD_F00D);
        chk("x3 orphan write busy", 32'(bus.busy1), 32'd0);

        // Mixed traffic checked by the model every cycle.
        for (int n = 0; n < 200; n++) begin
            bus.a1          = AW'($urandom_range(0, 7));
            bus.a2          = AW'($urandom_range(0, 7));
            bus.we3         = 1'($urandom_range(0, 1));
            bus.a3          = AW'($urandom_range(0, 7));
            bus.wd3         = $urandom;
            bus.issue_valid = 1'($urandom_range(0, 1));
            bus.issue_rd    = AW'($urandom_range(0, 7));
            bus.flush       = ($urandom_range(0, 15) == 0);
            reset_n         = ($urandom_range(0, 31) != 0);
            step();
        end
        reset_n = 1'b1;
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
